// File: rtl/sbp_pkg.sv
// Shared types and defaults for the sbp lookup pipeline.
// Latency: none (package only). Backpressure: n/a.
package sbp_pkg;

    typedef enum logic [1:0] {
        S_LOOKUP = 2'd0,
        S_DRAIN  = 2'd1,
        S_UPDATE = 2'd2
    } ingress_state_t;

    localparam int unsigned STAGE_BUBBLE  = '0;
    localparam int          BIT_POS_BITS  = 6;

    localparam int          STAGE_ID_BITS = 6;
    localparam int          LOCATION_BITS = 11;
    localparam int          RESULT_BITS   = 24;

endpackage

// File: rtl/sbp_lookup_ingress.sv
// Head of the lookup pipeline: merges lookups and atomic update batches, draining the tree before each batch.
// Latency: 1 cycle from accepted word to registered pipeline outputs.
// Backpressure: lookups held off while an update is pending, draining or issuing; update words accepted only in S_UPDATE.
module sbp_lookup_ingress
    import sbp_pkg::*;
#(
    parameter int STAGE_ID_BITS = sbp_pkg::STAGE_ID_BITS,
    parameter int LOCATION_BITS = sbp_pkg::LOCATION_BITS,
    parameter int RESULT_BITS   = sbp_pkg::RESULT_BITS,
    parameter int ROOT_STAGE_ID = 1,
    parameter int PIPE_DEPTH    = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     lkp_valid_i,
    output logic                     lkp_ready_o,
    input  logic [31:0]              lkp_ip_addr_i,
    input  logic                     upd_valid_i,
    output logic                     upd_ready_o,
    input  logic                     upd_last_i,
    input  logic [31:0]              upd_prefix_i,
    input  logic [BIT_POS_BITS-1:0]  upd_len_i,
    input  logic [STAGE_ID_BITS-1:0] upd_stage_i,
    input  logic [LOCATION_BITS-1:0] upd_loc_i,
    input  logic [RESULT_BITS-1:0]   upd_result_i,
    output logic                     update_o,
    output logic [31:0]              ip_addr_o,
    output logic [BIT_POS_BITS-1:0]  bit_pos_o,
    output logic [STAGE_ID_BITS-1:0] stage_id_o,
    output logic [LOCATION_BITS-1:0] location_o,
    output logic [RESULT_BITS-1:0]   result_o,
    output logic                     upd_active_o
);

    localparam int CNT_W = $clog2(PIPE_DEPTH + 1);

    typedef struct packed {
        logic                     update;
        logic [31:0]              ip_addr;
        logic [BIT_POS_BITS-1:0]  bit_pos;
        logic [STAGE_ID_BITS-1:0] stage_id;
        logic [LOCATION_BITS-1:0] location;
        logic [RESULT_BITS-1:0]   result;
    } pipe_t;

    localparam pipe_t PIPE_BUBBLE = '{
        update:   1'b0,
        ip_addr:  '0,
        bit_pos:  '0,
        stage_id: STAGE_ID_BITS'(STAGE_BUBBLE),
        location: '0,
        result:   '0
    };

    ingress_state_t   state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    pipe_t            pipe_q, pipe_nxt;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        lkp_ready_o = 1'b0;
        upd_ready_o = 1'b0;
        case (state)
            S_LOOKUP: begin
                // A pending update wins; the lookup simply waits for the batch to finish.
                lkp_ready_o = !upd_valid_i;
                if (upd_valid_i) begin
                    state_nxt = S_DRAIN;
                    cnt_nxt   = '0;
                end
            end
            S_DRAIN: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_W'(PIPE_DEPTH - 1)) begin
                    state_nxt = S_UPDATE;
                end
            end
            S_UPDATE: begin
                upd_ready_o = 1'b1;
                if (upd_valid_i && upd_last_i) begin
                    state_nxt = S_LOOKUP;
                end
            end
            default: state_nxt = S_LOOKUP;
        endcase
    end

    always_comb begin
        pipe_nxt = PIPE_BUBBLE;
        if (lkp_valid_i && lkp_ready_o) begin
            pipe_nxt.ip_addr  = lkp_ip_addr_i;
            pipe_nxt.stage_id = STAGE_ID_BITS'(ROOT_STAGE_ID);
        end else if (upd_valid_i && upd_ready_o) begin
            pipe_nxt.update   = 1'b1;
            pipe_nxt.ip_addr  = upd_prefix_i;
            pipe_nxt.bit_pos  = upd_len_i;
            pipe_nxt.stage_id = upd_stage_i;
            pipe_nxt.location = upd_loc_i;
            pipe_nxt.result   = upd_result_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_LOOKUP;
            cnt    <= '0;
            pipe_q <= PIPE_BUBBLE;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            pipe_q <= pipe_nxt;
        end
    end

    assign update_o     = pipe_q.update;
    assign ip_addr_o    = pipe_q.ip_addr;
    assign bit_pos_o    = pipe_q.bit_pos;
    assign stage_id_o   = pipe_q.stage_id;
    assign location_o   = pipe_q.location;
    assign result_o     = pipe_q.result;
    assign upd_active_o = (state != S_LOOKUP);

endmodule
